// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit engine among N_REQ byte sources.
// Optional build macro UART_ARB_PRIO0_EN makes requester 0 strict high priority.
module uart_tx_arbiter #(
  parameter int N_REQ  = 4,
  parameter int LOW_TO = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic                 tx_rdy,
  output logic                 tx_load,
  output logic [7:0]           tx_data,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 err,
  output logic [15:0]          tx_count
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(LOW_TO + 1);

  typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      ptr, win;
  logic [CW-1:0]      low_cnt, low_cnt_nxt;
  logic [N_REQ-1:0]   rr_req;
  logic               win_vld, prio_hit, take, timeout;
  logic               load_nxt;
  logic [N_REQ-1:0]   grant_nxt;
  logic [7:0]         data_nxt;

`ifdef UART_ARB_PRIO0_EN
  assign rr_req   = {req[N_REQ-1:1], 1'b0};
  assign prio_hit = req[0];
`else
  assign rr_req   = req;
  assign prio_hit = 1'b0;
`endif

  // Scan ptr+N down to ptr+1 so the last hit is the first in rotation order.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (rr_req[idx[PW-1:0]]) begin
        win     = idx[PW-1:0];
        win_vld = 1'b1;
      end
    end
    if (prio_hit) begin
      win     = '0;
      win_vld = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    low_cnt_nxt = low_cnt;
    take        = 1'b0;
    timeout     = 1'b0;
    case (state)
      IDLE: begin
        if (tx_rdy && win_vld) begin
          take        = 1'b1;
          low_cnt_nxt = '0;
          state_nxt   = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!tx_rdy) begin
          state_nxt = WAIT_HIGH;
        end else if (low_cnt == CW'(LOW_TO - 1)) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end else begin
          low_cnt_nxt = low_cnt + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (tx_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_nxt  = take;
    grant_nxt = take ? (N_REQ'(1) << win) : '0;
    data_nxt  = take ? req_data[8*int'(win) +: 8] : tx_data;
  end

  // Every output is a flop; ptr stays put on a priority-0 grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_load  <= 1'b0;
      grant    <= '0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      err      <= 1'b0;
      tx_count <= 16'h0000;
      ptr      <= PW'(N_REQ - 1);
      low_cnt  <= '0;
    end else begin
      tx_load <= load_nxt;
      grant   <= grant_nxt;
      tx_data <= data_nxt;
      busy    <= (state_nxt != IDLE);
      low_cnt <= low_cnt_nxt;
      if (take) begin
        tx_count <= tx_count + 16'd1;
        if (!prio_hit) ptr <= win;
      end
      if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a queue-free behavioural model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int LT = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           tx_rdy = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic           tx_load, busy, err;
  logic [7:0]     tx_data;
  logic [N-1:0]   grant;
  logic [15:0]    tx_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .LOW_TO(LT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .tx_rdy(tx_rdy),
    .tx_load(tx_load), .tx_data(tx_data), .grant(grant), .busy(busy),
    .err(err), .tx_count(tx_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transmit engine stand-in: after a load, tx_rdy drops eng_ld cycles later
  // and rises again eng_hd cycles after that. Mode 1 = stuck idle, 2 = stuck busy.
  int eng_mode = 0, eng_t = -1, eng_ld = 2, eng_hd = 100;
  bit eng_rand = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      eng_t = -1; tx_rdy = 1'b1;
    end else if (eng_mode == 2) begin
      eng_t = -1; tx_rdy = 1'b0;
    end else if (eng_mode == 1) begin
      eng_t = -1; tx_rdy = 1'b1;
    end else begin
      if (tx_load) begin
        eng_t = 0;
        if (eng_rand) begin
          eng_ld = $urandom_range(0, LT + 2);
          eng_hd = $urandom_range(0, 6);
        end
      end else if (eng_t >= 0) eng_t++;
      if (eng_t >= 0 && eng_t >= eng_ld + eng_hd) begin
        tx_rdy = 1'b1; eng_t = -1;
      end else if (eng_t >= 0 && eng_t >= eng_ld) tx_rdy = 1'b0;
      else tx_rdy = 1'b1;
    end
  end

  // Reference model: phase 0 idle, 1 waiting for accept, 2 waiting for frame end.
  bit           m_load, m_err;
  logic [N-1:0] m_grant;
  logic [7:0]   m_data;
  int           m_phase, m_low, m_ptr, m_cnt, m_w;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_load = 0; m_grant = '0; m_data = 8'h00;
      m_err = 0; m_cnt = 0; m_ptr = N - 1; m_low = 0;
    end else begin
      m_load = 0; m_grant = '0;
      if (m_phase == 0) begin
        if (tx_rdy && req != '0) begin
`ifdef UART_ARB_PRIO0_EN
          if (req[0]) m_w = 0;
          else begin m_w = pick(req, m_ptr); m_ptr = m_w; end
`else
          m_w = pick(req, m_ptr); m_ptr = m_w;
`endif
          m_load = 1; m_grant = N'(1) << m_w;
          m_data = req_data[8*m_w +: 8];
          m_cnt = (m_cnt + 1) % 65536;
          m_phase = 1; m_low = 0;
        end
      end else if (m_phase == 1) begin
        if (!tx_rdy) m_phase = 2;
        else begin
          m_low++;
          if (m_low == LT) begin m_err = 1; m_phase = 0; end
        end
      end else begin
        if (tx_rdy) m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("tx_load",  32'(tx_load),  32'(m_load));
      chk("grant",    32'(grant),    32'(m_grant));
      chk("tx_data",  32'(tx_data),  32'(m_data));
      chk("busy",     32'(busy),     32'(m_phase != 0));
      chk("err",      32'(err),      32'(m_err));
      chk("tx_count", 32'(tx_count), 32'(m_cnt));
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  task automatic wait_load(input int bound, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (tx_load) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s no tx_load within %0d cycles", name, bound);
    end
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n;
    n = 0;
    while (busy && n < bound) begin n++; step(); end
    if (busy) begin
      checks++; errors++;
      $display("FAIL %s busy still high after %0d cycles", name, bound);
    end
  endtask

  initial begin
    bit ok;
    int n;
    bit seen;
    logic [N-1:0] exp_g;

    // Reset state
    do_reset();
    cmp_en = 1'b1;
    chk("rst_load",  32'(tx_load),  0);
    chk("rst_grant", 32'(grant),    0);
    chk("rst_data",  32'(tx_data),  0);
    chk("rst_busy",  32'(busy),     0);
    chk("rst_err",   32'(err),      0);
    chk("rst_count", 32'(tx_count), 0);

    // Single request, one-cycle latency, busy for the whole frame
    req_data[23:16] = 8'hA5; req = 4'b0100;
    step();
    chk("s1_load",  32'(tx_load), 1);
    chk("s1_grant", 32'(grant),   32'(4'b0100));
    chk("s1_data",  32'(tx_data), 32'h A5);
    req = '0;
    n = 0;
    while (busy && n < 300) begin n++; step(); end
    chk("s1_busy_cycles", 32'(n), 103);
    chk("s1_count", 32'(tx_count), 1);
    chk("s1_err",   32'(err), 0);

    // Fairness with everyone requesting
    do_reset();
    eng_hd = 10;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_load(200, "s2_wait", ok);
      if (ok) begin
`ifdef UART_ARB_PRIO0_EN
        exp_g = 4'b0001;
`else
        exp_g = 4'(1 << (i % 4));
`endif
        chk("s2_grant", 32'(grant), 32'(exp_g));
        chk("s2_data",  32'(tx_data), 32'(req_data[8*$clog2(exp_g) +: 8]));
      end
      step();
    end
    req = '0;
    wait_idle(200, "s2_idle");
    chk("s2_count", 32'(tx_count), 8);

    // Engine busy while idle: no load until tx_rdy rises
    do_reset();
    eng_mode = 2;
    step();
    req = 4'b0001;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_load || grant != '0) seen = 1'b1;
    end
    chk("s3_no_load", 32'(seen), 0);
    eng_mode = 0;
    step(); step();
    chk("s3_load",  32'(tx_load), 1);
    chk("s3_grant", 32'(grant),   32'(4'b0001));
    req = '0;
    wait_idle(200, "s3_idle");

    // Handshake timeout: tx_rdy never falls after the load
    eng_mode = 1;
    step();
    req = 4'b0010;
    step();
    chk("s4_load",  32'(tx_load), 1);
    chk("s4_grant", 32'(grant),   32'(4'b0010));
    req = '0;
    for (int i = 0; i < LT - 1; i++) step();
    chk("s4_err_early", 32'(err), 0);
    step();
    chk("s4_err",  32'(err),  1);
    chk("s4_busy", 32'(busy), 0);
    eng_mode = 0;
    req = 4'b1000;
    wait_load(50, "s4_wait", ok);
    if (ok) chk("s4_next_grant", 32'(grant), 32'(4'b1000));
    req = '0;
    wait_idle(200, "s4_idle");
    chk("s4_err_sticky", 32'(err), 1);

    // Reset while waiting for the frame to finish
    req = 4'b0001;
    wait_load(50, "s5_wait", ok);
    req = '0;
    for (int i = 0; i < 5; i++) step();
    chk("s5_in_frame", 32'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1010;
    chk("s5_busy",  32'(busy),     0);
    chk("s5_count", 32'(tx_count), 0);
    chk("s5_err",   32'(err),      0);
    step();
    chk("s5_grant", 32'(grant), 32'(4'b0010));
    req = '0;
    wait_idle(200, "s5_idle");

`ifdef UART_ARB_PRIO0_EN
    // Requester 0 dominates, then the rest rotate from the reset pointer
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_load(200, "s6_wait0", ok);
      if (ok) chk("s6_prio_grant", 32'(grant), 32'(4'b0001));
      step();
    end
    req = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      wait_load(200, "s6_wait_rr", ok);
      if (ok) chk("s6_rr_grant", 32'(grant), 32'(4'(2 << i)));
      step();
    end
    req = '0;
    wait_idle(200, "s6_idle");
`endif

    // Randomized traffic, engine timing and occasional resets
    eng_rand = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i] && grant[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end else if (req[i] && $urandom_range(0, 99) == 0) req[i] = 1'b0;
      end
    end
    rst = 1'b0;
    req = '0;
    eng_rand = 1'b0;
    for (int i = 0; i < 30; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit engine among N_REQ byte sources, e.g. the TramelBlaze out_port path, a hardware status reporter and a debug dumper.
- Round-robin arbitration. Drives the engine's load strobe and 8-bit data.
- Sequences each byte by tracking the engine's TxRdy handshake: TxRdy falls when the engine accepts the byte and rises when the frame is finished.
- Sits between the requesters and transmitEngine, in the same clock domain as the synchronised reset.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LOW_TO, 8, maximum cycles to wait for tx_rdy to fall after tx_load before declaring a handshake error.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester "byte pending"; level, held until that requester's grant.
- req_data  in  8*N_REQ  byte for requester i in bits [8i+7:8i]; held stable while req[i]=1.
- tx_rdy  in  1  TxRdy from transmitEngine; 1 = idle, able to accept a byte.
- tx_load  out  1  one-cycle load pulse to transmitEngine.
- tx_data  out  8  byte to transmitEngine; valid when tx_load=1 and held until the next load.
- grant  out  N_REQ  one-hot, one-cycle pulse coincident with tx_load; tells the winner its byte was taken.
- busy  out  1  1 whenever the FSM is not in IDLE.
- err  out  1  sticky handshake-timeout flag; cleared only by rst.
- tx_count  out  16  count of bytes loaded; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (synchronous, rst=1 at the clock edge):
  - state=IDLE; tx_load=0; grant=0; tx_data=8'h00; busy=0; err=0; tx_count=0.
  - Round-robin pointer ptr=N_REQ-1, so requester 0 has first priority after reset.
  - A reset mid-byte abandons the byte with no grant re-issue; the transmit engine is reset by the same rst.
- All outputs are registered.
- FSM states: IDLE, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - If tx_rdy=1 and |req, pick the winner w as the first set req index scanning ptr+1, ptr+2, ... modulo N_REQ.
  - On that edge: tx_load<=1, grant<=onehot(w), tx_data<=req_data[w], ptr<=w, tx_count<=tx_count+1, state<=WAIT_LOW, low counter cleared.
  - Latency: req sampled at edge N gives tx_load/grant high during cycle N+1, for exactly one cycle.
  - If tx_rdy=0 in IDLE (engine busy from before reset or externally loaded), no grant; remain in IDLE.
- WAIT_LOW:
  - tx_load and grant return to 0.
  - If tx_rdy=0, go to WAIT_HIGH.
  - Otherwise increment the low counter; when it reaches LOW_TO, set err<=1 and go to IDLE.
- WAIT_HIGH: stay until tx_rdy=1, then go to IDLE.
  - The earliest next grant is the edge after returning to IDLE, giving at least one idle cycle between loads.
- Requester handshake:
  - Requester i must hold req[i] and its data until it sees grant[i].
  - It may reassert on the cycle after grant for back-to-back bytes; it then competes fairly with the others.
  - Deasserting req before grant withdraws the request, with no side effects.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,...,N_REQ-1,0,...
- Simultaneous events:
  - rst has priority over everything.
  - A req change in the same cycle as an IDLE grant decision uses the value sampled at that edge.
- Width rules: ptr is ceil(log2(N_REQ)) bits with modulo-N_REQ wrap; tx_count is modulo 2^16.

Optional Feature:
- Macro: UART_ARB_PRIO0_EN.
- Defined: requester 0 is strict high priority. If req[0]=1 in IDLE it wins regardless of ptr, and ptr is not updated on its grant. Requesters 1..N_REQ-1 round-robin among themselves when req[0]=0.
- Undefined: pure round-robin over all requesters as described above; no priority logic is synthesised.

Test Plan:
- Single request after reset: rst 2 cycles, tx_rdy=1, req=4'b0100, req_data[23:16]=8'hA5.
  - Required: one cycle later tx_load=1, grant=4'b0100, tx_data=8'hA5.
  - Model drops tx_rdy after 2 cycles and raises it after 100 cycles; busy=1 throughout, then 0.
  - tx_count=1, err=0.
- Fairness: req=4'b1111 held for 8 bytes, engine model as above.
  - Required grant order 0,1,2,3,0,1,2,3; tx_data matches 8'h10,8'h11,8'h12,8'h13 per requester; tx_count=8.
- Engine busy in IDLE: tx_rdy=0, req=4'b0001 for 20 cycles.
  - Required: no tx_load and no grant.
  - Raise tx_rdy: grant=4'b0001 one cycle later.
- Timeout: tx_rdy held at 1 after a load.
  - Required: err=1 exactly LOW_TO cycles into WAIT_LOW; FSM back to IDLE.
  - Next request is still served; err stays 1 until rst.
- Reset mid-byte: rst=1 while in WAIT_HIGH.
  - Required: next cycle state IDLE, busy=0, tx_count=0, ptr reset.
  - With req=4'b1010 after reset, the first grant goes to requester 1.
- With UART_ARB_PRIO0_EN defined: req=4'b1111 continuously.
  - Required: requester 0 granted every byte; after req[0] drops, grants rotate 1,2,3.
